// File: rtl/wrr_rank_engine_if.sv
// Request, weight-configuration and response channels of the WRR rank engine.
interface wrr_rank_engine_if #(
   parameter int CLASS_WIDTH         = 5,
   parameter int WEIGHT_WIDTH        = 16,
   parameter int PIFO_OVERFLOW_WIDTH = 1,
   parameter int PIFO_ROUND_WIDTH    = 18,
   parameter int RESULT_WIDTH        = 32
);
   logic                           req_valid;
   logic                           req_ready;
   logic [CLASS_WIDTH-1:0]         req_class_id;
   logic [PIFO_OVERFLOW_WIDTH-1:0] last_pifo_overflow;
   logic [PIFO_ROUND_WIDTH-1:0]    last_pifo_round;
   logic                           cfg_valid;
   logic [CLASS_WIDTH-1:0]         cfg_class_id;
   logic [WEIGHT_WIDTH-1:0]        cfg_weight;
   logic                           resp_valid;
   logic                           resp_ready;
   logic [RESULT_WIDTH-1:0]        resp_data;

   modport master (
      output req_valid, req_class_id, last_pifo_overflow, last_pifo_round,
      output cfg_valid, cfg_class_id, cfg_weight, resp_ready,
      input  req_ready, resp_valid, resp_data
   );

   modport slave (
      input  req_valid, req_class_id, last_pifo_overflow, last_pifo_round,
      input  cfg_valid, cfg_class_id, cfg_weight, resp_ready,
      output req_ready, resp_valid, resp_data
   );
endinterface

// File: rtl/wrr_rank_engine.sv
// Weighted-round-robin PIFO rank calculator: per-class round/credit state,
// runtime weight table, epoch-aware rebasing against the last dequeued rank.
module wrr_rank_engine #(
   parameter int CLASS_WIDTH         = 5,
   parameter int WEIGHT_WIDTH        = 16,
   parameter int PIFO_OVERFLOW_WIDTH = 1,
   parameter int PIFO_ROUND_WIDTH    = 18,
   parameter int PIFO_ADDR_WIDTH     = 12,
   parameter int RESULT_WIDTH        = 32
) (
   input logic              clk,
   input logic              rst,
   wrr_rank_engine_if.slave bus
);
   localparam int N  = 1 << CLASS_WIDTH;
   localparam int OW = PIFO_OVERFLOW_WIDTH;
   localparam int RW = PIFO_ROUND_WIDTH;
   localparam int WW = WEIGHT_WIDTH;

   typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;
   state_t state, state_nxt;

   logic [OW-1:0] ovf_tbl    [N];
   logic [RW-1:0] round_tbl  [N];
   logic [WW-1:0] credit_tbl [N];
   logic [WW-1:0] weight_tbl [N];

   logic [CLASS_WIDTH-1:0] lat_class;
   logic [OW-1:0]          t_ovf, l_ovf, c_ovf, r_ovf;
   logic [RW-1:0]          t_round, l_round, c_round, r_round;
   logic [WW-1:0]          t_credit, t_weight, c_credit, r_credit, ew;

   logic accept, handshake;
   assign accept    = (state == IDLE) && bus.req_valid;
   assign handshake = (state == RESP) && bus.resp_ready;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt      = state;
      bus.req_ready  = 1'b0;
      bus.resp_valid = 1'b0;
      case (state)
         IDLE: begin
            bus.req_ready = !rst;
            if (bus.req_valid) state_nxt = CALC;
         end
         CALC: state_nxt = RESP;
         RESP: begin
            bus.resp_valid = 1'b1;
            if (bus.resp_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Operands are frozen at acceptance so later cfg writes cannot disturb this request.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lat_class <= '0;
         t_ovf     <= '0;
         t_round   <= '0;
         t_credit  <= '0;
         t_weight  <= '0;
         l_ovf     <= '0;
         l_round   <= '0;
      end else if (accept) begin
         lat_class <= bus.req_class_id;
         t_ovf     <= ovf_tbl[bus.req_class_id];
         t_round   <= round_tbl[bus.req_class_id];
         t_credit  <= credit_tbl[bus.req_class_id];
         t_weight  <= weight_tbl[bus.req_class_id];
         l_ovf     <= bus.last_pifo_overflow;
         l_round   <= bus.last_pifo_round;
      end
   end

   always_comb begin
      ew       = (t_weight == '0) ? WW'(1) : t_weight;
      c_ovf    = t_ovf;
      c_round  = t_round;
      c_credit = ew - WW'(1);
      if (t_ovf != l_ovf && l_round < t_round) begin
         c_ovf   = l_ovf;
         c_round = l_round;
      end else if (t_ovf == l_ovf && t_round < l_round) begin
         c_round = l_round;
      end else if (t_credit != '0) begin
         c_credit = t_credit - WW'(1);
      end else if (t_round == '1) begin
         c_ovf   = t_ovf + OW'(1);
         c_round = '0;
      end else begin
         c_round = t_round + RW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ovf    <= '0;
         r_round  <= '0;
         r_credit <= '0;
      end else if (state == CALC) begin
         r_ovf    <= c_ovf;
         r_round  <= c_round;
         r_credit <= c_credit;
      end
   end

   assign bus.resp_data = (state == RESP)
      ? RESULT_WIDTH'({1'b1, r_ovf, r_round, {PIFO_ADDR_WIDTH{1'b0}}})
      : '0;

   // NOTE: the class tables must return to defaults on reset, so they are flops rather than RAM.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N; i++) begin
            ovf_tbl[i]    <= '0;
            round_tbl[i]  <= '0;
            credit_tbl[i] <= '0;
            weight_tbl[i] <= WW'(1);
         end
      end else begin
         if (handshake) begin
            ovf_tbl[lat_class]    <= r_ovf;
            round_tbl[lat_class]  <= r_round;
            credit_tbl[lat_class] <= r_credit;
         end
         // Placed after the write-back so a same-class cfg clear takes priority.
         if (bus.cfg_valid) begin
            weight_tbl[bus.cfg_class_id] <= bus.cfg_weight;
            credit_tbl[bus.cfg_class_id] <= '0;
         end
      end
   end
endmodule
